// File: rtl/hyperbus_trans_arbiter.sv
// Round-robin arbiter sharing one HyperBus PHY transaction port (trans/tx/rx)
// between NR_REQ requesters; the grant is held until the last beat or a PHY error.
module hyperbus_trans_arbiter #(
  parameter int NR_REQ      = 2,
  parameter int NR_CS       = 2,
  parameter int BURST_WIDTH = 12
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NR_REQ-1:0]             req_valid_i,
  output logic [NR_REQ-1:0]             req_ready_o,
  input  logic [NR_REQ*32-1:0]          req_address_i,
  input  logic [NR_REQ*NR_CS-1:0]       req_cs_i,
  input  logic [NR_REQ-1:0]             req_write_i,
  input  logic [NR_REQ*BURST_WIDTH-1:0] req_burst_i,
  input  logic [NR_REQ-1:0]             req_address_space_i,
  input  logic [NR_REQ-1:0]             req_tx_valid_i,
  output logic [NR_REQ-1:0]             req_tx_ready_o,
  input  logic [NR_REQ*16-1:0]          req_tx_data_i,
  input  logic [NR_REQ*2-1:0]           req_tx_strb_i,
  output logic [NR_REQ-1:0]             req_rx_valid_o,
  input  logic [NR_REQ-1:0]             req_rx_ready_i,
  output logic [15:0]                   req_rx_data_o,
  output logic [NR_REQ-1:0]             req_error_o,
  output logic                          trans_valid_o,
  input  logic                          trans_ready_i,
  output logic [31:0]                   trans_address_o,
  output logic [NR_CS-1:0]              trans_cs_o,
  output logic                          trans_write_o,
  output logic [BURST_WIDTH-1:0]        trans_burst_o,
  output logic                          trans_address_space_o,
  input  logic                          trans_error_i,
  output logic                          tx_valid_o,
  input  logic                          tx_ready_i,
  output logic [15:0]                   tx_data_o,
  output logic [1:0]                    tx_strb_o,
  input  logic                          rx_valid_i,
  output logic                          rx_ready_o,
  input  logic [15:0]                   rx_data_i
);

  localparam int IDX_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DATA} state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       g_q, g_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [BURST_WIDTH-1:0] beats_left_q, beats_left_d;

  logic [31:0]            addr_p0;
  logic [NR_CS-1:0]       cs_p0;
  logic                   write_p0;
  logic [BURST_WIDTH-1:0] burst_p0;
  logic                   aspace_p0;

  logic                   sel_found;
  logic [IDX_W-1:0]       sel_idx;
  int                     idx;
  logic                   beat;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] v);
    return (int'(v) == NR_REQ - 1) ? '0 : v + 1'b1;
  endfunction

  // Register writes move exactly one beat; a zero burst still moves one beat.
  function automatic logic [BURST_WIDTH-1:0] load_beats(input logic aspace, input logic wr,
                                                        input logic [BURST_WIDTH-1:0] burst);
    if (aspace && wr) return BURST_WIDTH'(1);
    if (burst == '0)  return BURST_WIDTH'(1);
    return burst;
  endfunction

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = rr_ptr_q;
    idx       = 0;
    for (int i = 0; i < NR_REQ; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NR_REQ) idx = idx - NR_REQ;
      if (!sel_found && req_valid_i[idx]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(idx);
      end
    end
  end

  // ---- stage p0: capture of the selected requester's transaction fields ----
  always_ff @(posedge clk_i) begin
    if (state_q == IDLE && sel_found) begin
      addr_p0   <= req_address_i[int'(sel_idx)*32 +: 32];
      cs_p0     <= req_cs_i[int'(sel_idx)*NR_CS +: NR_CS];
      write_p0  <= req_write_i[sel_idx];
      burst_p0  <= req_burst_i[int'(sel_idx)*BURST_WIDTH +: BURST_WIDTH];
      aspace_p0 <= req_address_space_i[sel_idx];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      g_q          <= '0;
      rr_ptr_q     <= '0;
      beats_left_q <= '0;
    end else begin
      state_q      <= state_d;
      g_q          <= g_d;
      rr_ptr_q     <= rr_ptr_d;
      beats_left_q <= beats_left_d;
    end
  end

  always_comb begin
    state_d               = state_q;
    g_d                   = g_q;
    rr_ptr_d              = rr_ptr_q;
    beats_left_d          = beats_left_q;
    beat                  = 1'b0;
    req_ready_o           = '0;
    req_tx_ready_o        = '0;
    req_rx_valid_o        = '0;
    req_rx_data_o         = '0;
    req_error_o           = '0;
    trans_valid_o         = 1'b0;
    trans_address_o       = '0;
    trans_cs_o            = '0;
    trans_write_o         = 1'b0;
    trans_burst_o         = '0;
    trans_address_space_o = 1'b0;
    tx_valid_o            = 1'b0;
    tx_data_o             = '0;
    tx_strb_o             = '0;
    rx_ready_o            = 1'b0;

    case (state_q)
      IDLE: begin
        if (sel_found) begin
          g_d     = sel_idx;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        trans_valid_o         = 1'b1;
        trans_address_o       = addr_p0;
        trans_cs_o            = cs_p0;
        trans_write_o         = write_p0;
        trans_burst_o         = burst_p0;
        trans_address_space_o = aspace_p0;
        if (trans_error_i) begin
          req_error_o[g_q] = 1'b1;
          rr_ptr_d         = next_idx(g_q);
          state_d          = IDLE;
        end else if (trans_ready_i) begin
          req_ready_o[g_q] = 1'b1;
          beats_left_d     = load_beats(aspace_p0, write_p0, burst_p0);
          state_d          = DATA;
        end
      end
      DATA: begin
        // An error cycle leaves every data handshake deasserted.
        if (trans_error_i) begin
          req_error_o[g_q] = 1'b1;
          rr_ptr_d         = next_idx(g_q);
          state_d          = IDLE;
        end else begin
          tx_valid_o          = req_tx_valid_i[g_q];
          req_tx_ready_o[g_q] = tx_ready_i;
          tx_data_o           = req_tx_data_i[int'(g_q)*16 +: 16];
          tx_strb_o           = req_tx_strb_i[int'(g_q)*2 +: 2];
          rx_ready_o          = req_rx_ready_i[g_q];
          req_rx_valid_o[g_q] = rx_valid_i;
          req_rx_data_o       = rx_data_i;
          beat = write_p0 ? (req_tx_valid_i[g_q] && tx_ready_i)
                          : (rx_valid_i && req_rx_ready_i[g_q]);
          if (beat) begin
            if (beats_left_q <= BURST_WIDTH'(1)) begin
              beats_left_d = '0;
              rr_ptr_d     = next_idx(g_q);
              state_d      = IDLE;
            end else begin
              beats_left_d = beats_left_q - 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_hyperbus_trans_arbiter.sv
// Directed bench for hyperbus_trans_arbiter: arbitration order, burst lengths,
// tx/rx routing, error abort and asynchronous reset.
module tb_hyperbus_trans_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_address;
  logic [3:0]  req_cs;
  logic [1:0]  req_write;
  logic [23:0] req_burst;
  logic [1:0]  req_aspace;
  logic [1:0]  req_tx_valid;
  logic [1:0]  req_tx_ready;
  logic [31:0] req_tx_data;
  logic [3:0]  req_tx_strb;
  logic [1:0]  req_rx_valid;
  logic [1:0]  req_rx_ready;
  logic [15:0] req_rx_data;
  logic [1:0]  req_error;
  logic        trans_valid, trans_ready, trans_write, trans_aspace, trans_error;
  logic [31:0] trans_address;
  logic [1:0]  trans_cs;
  logic [11:0] trans_burst;
  logic        tx_valid, tx_ready, rx_valid, rx_ready;
  logic [15:0] tx_data, rx_data;
  logic [1:0]  tx_strb;

  int tests = 0;
  int fails = 0;
  int hs;
  logic [4:0] pat;

  hyperbus_trans_arbiter #(.NR_REQ(2), .NR_CS(2), .BURST_WIDTH(12)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_address_i(req_address), .req_cs_i(req_cs), .req_write_i(req_write),
    .req_burst_i(req_burst), .req_address_space_i(req_aspace),
    .req_tx_valid_i(req_tx_valid), .req_tx_ready_o(req_tx_ready),
    .req_tx_data_i(req_tx_data), .req_tx_strb_i(req_tx_strb),
    .req_rx_valid_o(req_rx_valid), .req_rx_ready_i(req_rx_ready),
    .req_rx_data_o(req_rx_data), .req_error_o(req_error),
    .trans_valid_o(trans_valid), .trans_ready_i(trans_ready),
    .trans_address_o(trans_address), .trans_cs_o(trans_cs),
    .trans_write_o(trans_write), .trans_burst_o(trans_burst),
    .trans_address_space_o(trans_aspace), .trans_error_i(trans_error),
    .tx_valid_o(tx_valid), .tx_ready_i(tx_ready), .tx_data_o(tx_data), .tx_strb_o(tx_strb),
    .rx_valid_i(rx_valid), .rx_ready_o(rx_ready), .rx_data_i(rx_data)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int k, input logic [31:0] addr, input logic [1:0] cs,
                         input logic wr, input logic [11:0] burst, input logic asp);
    req_address[k*32 +: 32] = addr;
    req_cs[k*2 +: 2]        = cs;
    req_write[k]            = wr;
    req_burst[k*12 +: 12]   = burst;
    req_aspace[k]           = asp;
    req_valid[k]            = 1'b1;
  endtask

  // Called one cycle after the request was raised: ISSUE is expected, the PHY accepts.
  task automatic do_issue(input int g, input logic [31:0] addr, input logic [11:0] burst);
    check("issue_valid", {31'd0, trans_valid}, 32'd1);
    check("issue_addr", trans_address, addr);
    check("issue_burst", {20'd0, trans_burst}, {20'd0, burst});
    check("issue_no_rx", {31'd0, rx_ready}, 32'd0);
    trans_ready = 1'b1;
    #1;
    check("issue_ready", {30'd0, req_ready}, 32'd1 << g);
    tick();
    trans_ready  = 1'b0;
    req_valid[g] = 1'b0;
  endtask

  task automatic rx_beat(input int g, input logic [15:0] d);
    rx_valid = 1'b1;
    rx_data  = d;
    #1;
    check("rx_valid_route", {30'd0, req_rx_valid}, 32'd1 << g);
    check("rx_data", {16'd0, req_rx_data}, {16'd0, d});
    tick();
    rx_valid = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0;
    req_valid = '0; req_address = '0; req_cs = '0; req_write = '0; req_burst = '0;
    req_aspace = '0; req_tx_valid = '0; req_tx_data = '0; req_tx_strb = '0;
    req_rx_ready = '0; trans_ready = 1'b0; trans_error = 1'b0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    tick();
    tick();
    check("rst_trans_valid", {31'd0, trans_valid}, 32'd0);
    check("rst_handshakes", {24'd0, req_ready, req_error, tx_valid, rx_ready, req_rx_valid},
          32'd0);
    rst_ni = 1'b1;
    tick();

    // Simultaneous requests from reset: 0 first, then 1 (burst 0 = one beat)
    set_req(0, 32'h200, 2'b01, 1'b0, 12'd1, 1'b0);
    set_req(1, 32'h300, 2'b10, 1'b0, 12'd0, 1'b0);
    req_rx_ready = 2'b11;
    #1;
    check("idle_no_issue", {31'd0, trans_valid}, 32'd0);
    tick();
    do_issue(0, 32'h200, 12'd1);
    rx_beat(0, 16'h0055);
    tick();
    do_issue(1, 32'h300, 12'd0);
    rx_beat(1, 16'h0066);
    check("burst0_one_beat", {31'd0, rx_ready}, 32'd0);

    // Requester 0 read, burst 4
    set_req(0, 32'h100, 2'b01, 1'b0, 12'd4, 1'b0);
    tick();
    check("t1_cs", {30'd0, trans_cs}, 32'd1);
    check("t1_write", {31'd0, trans_write}, 32'd0);
    do_issue(0, 32'h100, 12'd4);
    for (int b = 0; b < 4; b++) rx_beat(0, 16'h00A0 + 16'(b));
    check("t1_idle", {31'd0, rx_ready}, 32'd0);
    check("t1_rr_ptr", {31'd0, dut.rr_ptr_q}, 32'd1);

    // Simultaneous requests with rr_ptr=1: 1 then 0
    set_req(0, 32'h400, 2'b01, 1'b0, 12'd1, 1'b0);
    set_req(1, 32'h500, 2'b01, 1'b0, 12'd1, 1'b0);
    tick();
    do_issue(1, 32'h500, 12'd1);
    rx_beat(1, 16'h0011);
    tick();
    do_issue(0, 32'h400, 12'd1);
    rx_beat(0, 16'h0022);

    // Requester 1 write burst 3 with a 2-cycle tx_valid gap
    set_req(1, 32'h600, 2'b01, 1'b1, 12'd3, 1'b0);
    req_tx_valid[0] = 1'b1;
    req_tx_data     = {16'h1234, 16'hDEAD};
    req_tx_strb     = 4'b1001;
    tx_ready        = 1'b1;
    tick();
    do_issue(1, 32'h600, 12'd3);
    pat = 5'b11001;
    hs  = 0;
    for (int c = 0; c < 5; c++) begin
      req_tx_valid[1] = pat[c];
      #1;
      if (tx_valid && tx_ready) hs++;
      check("t3_tx_valid", {31'd0, tx_valid}, {31'd0, pat[c]});
      check("t3_req0_tx_ready", {31'd0, req_tx_ready[0]}, 32'd0);
      if (c == 0) begin
        check("t3_tx_data", {16'd0, tx_data}, 32'h1234);
        check("t3_tx_strb", {30'd0, tx_strb}, 32'd2);
      end
      tick();
    end
    req_tx_valid[1] = 1'b1;
    #1;
    check("t3_hs_count", hs, 32'd3);
    check("t3_done", {31'd0, tx_valid}, 32'd0);
    req_tx_valid = '0;
    tx_ready     = 1'b0;

    // Register write: one beat regardless of burst=8
    set_req(0, 32'h10, 2'b01, 1'b1, 12'd8, 1'b1);
    tick();
    check("t4_aspace", {31'd0, trans_aspace}, 32'd1);
    check("t4_write", {31'd0, trans_write}, 32'd1);
    do_issue(0, 32'h10, 12'd8);
    req_tx_valid[0] = 1'b1;
    tx_ready        = 1'b1;
    #1;
    check("t4_tx_valid", {31'd0, tx_valid}, 32'd1);
    tick();
    check("t4_single_beat", {31'd0, tx_valid}, 32'd0);
    req_tx_valid = '0;
    tx_ready     = 1'b0;

    // PHY error after 2 of 4 read beats
    set_req(0, 32'h800, 2'b01, 1'b0, 12'd4, 1'b0);
    tick();
    do_issue(0, 32'h800, 12'd4);
    rx_beat(0, 16'h0001);
    rx_beat(0, 16'h0002);
    rx_valid    = 1'b1;
    trans_error = 1'b1;
    #1;
    check("t5_error_pulse", {30'd0, req_error}, 32'd1);
    check("t5_rx_blocked", {31'd0, rx_ready}, 32'd0);
    check("t5_rx_valid_blocked", {30'd0, req_rx_valid}, 32'd0);
    tick();
    trans_error = 1'b0;
    rx_valid    = 1'b0;
    #1;
    check("t5_error_gone", {30'd0, req_error}, 32'd0);
    check("t5_idle", {31'd0, rx_ready}, 32'd0);
    set_req(1, 32'h900, 2'b01, 1'b0, 12'd1, 1'b0);
    tick();
    do_issue(1, 32'h900, 12'd1);
    rx_beat(1, 16'h0077);

    // Asynchronous reset during DATA
    set_req(0, 32'hA00, 2'b01, 1'b0, 12'd4, 1'b0);
    tick();
    do_issue(0, 32'hA00, 12'd4);
    rx_beat(0, 16'h0003);
    rx_valid = 1'b1;
    #1;
    check("t6_in_data", {30'd0, req_rx_valid}, 32'd1);
    rst_ni = 1'b0;
    #1;
    check("t6_rst_rx_valid", {30'd0, req_rx_valid}, 32'd0);
    check("t6_rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("t6_rst_trans_valid", {31'd0, trans_valid}, 32'd0);
    rx_valid = 1'b0;
    tick();
    rst_ni = 1'b1;
    set_req(1, 32'hB00, 2'b10, 1'b0, 12'd1, 1'b0);
    #1;
    check("t6_no_early_issue", {31'd0, trans_valid}, 32'd0);
    tick();
    do_issue(1, 32'hB00, 12'd1);
    rx_beat(1, 16'h0099);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
